// File: rtl/fadd_pipe.sv
// fadd_pipe: three-stage IEEE-754 adder (align, add/round, normalise/pack), RNE rounding, valid/ready.
// Define FADD_PIPE_DENORM_EN for gradual underflow; otherwise subnormals flush to signed zero.
module fadd_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] res,
    output logic                 ovf,
    output logic                 nv
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam int F = MAN_W + 4;   // hidden, mantissa, guard, round, sticky
    localparam logic [EXP_W-1:0] EMAX  = '1;
    localparam logic [EXP_W-1:0] E_ONE = EXP_W'(1);
    localparam logic [EXP_W:0]   X_ONE = (EXP_W+1)'(1);
    localparam logic [W-1:0]     QNAN  = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic             sgn;
        logic             eff_sub;
        logic [EXP_W-1:0] exp;
        logic [F-1:0]     sig_l;
        logic [F-1:0]     sig_s;
        logic             spc;
        logic             nv;
        logic [W-1:0]     spc_res;
    } s1_t;

    typedef struct packed {
        logic             sgn;
        logic             zero;
        logic [EXP_W:0]   exp;
        logic [MAN_W+1:0] sig;
        logic             spc;
        logic             nv;
        logic [W-1:0]     spc_res;
    } s2_t;

    function automatic int clz(input logic [F-1:0] v);
        int c;
        c = F;
        for (int i = 0; i < F; i++)
            if (v[i]) c = F - 1 - i;
        return c;
    endfunction

    logic             adv;
    logic [2:0]       vld_d, vld_q;
    s1_t              s1_d, s1_q;
    s2_t              s2_d, s2_q;
    logic [W-1:0]     res_d, res_q;
    logic             ovf_d, ovf_q, nv_d, nv_q;

    assign adv       = !vld_q[2] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[2];
    assign res       = res_q;
    assign ovf       = ovf_q;
    assign nv        = nv_q;

    // ---------------- stage 1: classify, order, align ----------------
    logic             sa, sb, a_nan, b_nan, a_inf, b_inf, a_big;
    logic [EXP_W-1:0] ea, eb, el, es, el1, es1, shift, sh_c;
    logic [MAN_W-1:0] ma, mb, ml, ms;
    logic [F-1:0]     sig_s;
    logic [2*F-1:0]   ext;

    always_comb begin
        vld_d = {vld_q[1:0], in_valid};
        sa    = a[W-1];
        sb    = b[W-1];
        ea    = a[W-2:MAN_W];
        eb    = b[W-2:MAN_W];
        a_nan = (ea == EMAX) && (a[MAN_W-1:0] != '0);
        b_nan = (eb == EMAX) && (b[MAN_W-1:0] != '0);
        a_inf = (ea == EMAX) && (a[MAN_W-1:0] == '0);
        b_inf = (eb == EMAX) && (b[MAN_W-1:0] == '0);
`ifdef FADD_PIPE_DENORM_EN
        ma = a[MAN_W-1:0];
        mb = b[MAN_W-1:0];
`else
        ma = (ea == '0) ? '0 : a[MAN_W-1:0];
        mb = (eb == '0) ? '0 : b[MAN_W-1:0];
`endif
        a_big = {ea, ma} >= {eb, mb};
        el    = a_big ? ea : eb;
        ml    = a_big ? ma : mb;
        es    = a_big ? eb : ea;
        ms    = a_big ? mb : ma;
        el1   = (el == '0) ? E_ONE : el;
        es1   = (es == '0) ? E_ONE : es;
        shift = el1 - es1;
        // shifting by F already pushes every bit into the sticky half
        sh_c  = (int'(shift) > F) ? EXP_W'(F) : shift;
        sig_s = {es != '0, ms, 3'b000};
        ext   = {sig_s, {F{1'b0}}} >> sh_c;

        s1_d.sgn     = a_big ? sa : sb;
        s1_d.eff_sub = sa ^ sb;
        s1_d.exp     = el1;
        s1_d.sig_l   = {el != '0, ml, 3'b000};
        s1_d.sig_s   = {ext[2*F-1:F+1], ext[F] | (|ext[F-1:0])};
        s1_d.nv      = a_nan | b_nan | (a_inf & b_inf & (sa ^ sb));
        s1_d.spc     = a_nan | b_nan | a_inf | b_inf;
        s1_d.spc_res = s1_d.nv ? QNAN : (a_inf ? a : b);
    end

    // ---------------- stage 2: add, normalise, round ----------------
    logic [F:0]     sum;
    logic [F-1:0]   nrm;
    logic [EXP_W:0] e2;
    logic           under, rnd_up;
    int             lz, lsh;

    always_comb begin
        sum   = s1_q.eff_sub ? ({1'b0, s1_q.sig_l} - {1'b0, s1_q.sig_s})
                             : ({1'b0, s1_q.sig_l} + {1'b0, s1_q.sig_s});
        lz    = clz(sum[F-1:0]);
        lsh   = 0;
        under = 1'b0;
        if (sum[F]) begin
            nrm = {sum[F:2], sum[1] | sum[0]};
            e2  = {1'b0, s1_q.exp} + X_ONE;
        end else begin
`ifdef FADD_PIPE_DENORM_EN
            // stop at exponent 1; anything left unnormalised packs as subnormal
            lsh = (lz > int'(s1_q.exp) - 1) ? int'(s1_q.exp) - 1 : lz;
`else
            lsh   = lz;
            under = lz >= int'(s1_q.exp);
`endif
            nrm = sum[F-1:0] << lsh;
            e2  = (EXP_W+1)'(int'(s1_q.exp) - lsh);
        end
        rnd_up       = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
        s2_d.zero    = (sum == '0) | under;
        s2_d.sgn     = s2_d.zero ? (s1_q.sgn & ~s1_q.eff_sub) : s1_q.sgn;
        s2_d.exp     = e2;
        s2_d.sig     = {1'b0, nrm[F-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
        s2_d.spc     = s1_q.spc;
        s2_d.nv      = s1_q.nv;
        s2_d.spc_res = s1_q.spc_res;
    end

    // ---------------- stage 3: renormalise, pack ----------------
    logic [EXP_W:0]   e3;
    logic [MAN_W-1:0] m3;

    always_comb begin
        if (s2_q.sig[MAN_W+1]) begin
            m3 = s2_q.sig[MAN_W:1];
            e3 = s2_q.exp + X_ONE;
        end else if (s2_q.sig[MAN_W]) begin
            m3 = s2_q.sig[MAN_W-1:0];
            e3 = s2_q.exp;
        end else begin
            m3 = s2_q.sig[MAN_W-1:0];
            e3 = '0;
        end
        ovf_d = 1'b0;
        nv_d  = 1'b0;
        res_d = {s2_q.sgn, e3[EXP_W-1:0], m3};
        if (s2_q.spc) begin
            res_d = s2_q.spc_res;
            nv_d  = s2_q.nv;
        end else if (s2_q.zero) begin
            res_d = {s2_q.sgn, {(W-1){1'b0}}};
        end else if (e3 >= {1'b0, EMAX}) begin
            res_d = {s2_q.sgn, EMAX, {MAN_W{1'b0}}};
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            s1_q  <= '0;
            s2_q  <= '0;
            res_q <= '0;
            ovf_q <= 1'b0;
            nv_q  <= 1'b0;
        end else if (adv) begin
            vld_q <= vld_d;
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            res_q <= res_d;
            ovf_q <= ovf_d;
            nv_q  <= nv_d;
        end
    end
endmodule

// File: tb/tb_fadd_pipe.sv
// Self-checking bench for fadd_pipe: exact big-integer reference model plus directed vectors.
`timescale 1ns/1ps
module tb_fadd_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] res;
    logic        ovf, nv;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    fadd_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .ovf(ovf), .nv(nv)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        nv;
    } rslt_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        nv;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Exact value in units of 2^-149 (smallest subnormal).
    function automatic logic signed [299:0] val_of(input logic [31:0] x);
        logic signed [299:0] v;
        if (x[30:23] == 8'h00) begin
`ifdef FADD_PIPE_DENORM_EN
            v = 300'(x[22:0]);
`else
            v = '0;
`endif
        end else begin
            v = 300'({1'b1, x[22:0]}) << (x[30:23] - 8'd1);
        end
        return x[31] ? -v : v;
    endfunction

    function automatic rslt_t model(input logic [31:0] x, input logic [31:0] y);
        rslt_t r;
        logic xnan, ynan, xinf, yinf, rs, zs;
        logic signed [299:0] s;
        logic [299:0] mag, rem, half;
        logic [24:0] keep;
        int p, sh;
        r    = '0;
        xnan = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        ynan = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        xinf = (x[30:23] == 8'hFF) && (x[22:0] == 0);
        yinf = (y[30:23] == 8'hFF) && (y[22:0] == 0);
        zs   = (x[31] == y[31]) ? x[31] : 1'b0;
        if (xnan || ynan || (xinf && yinf && (x[31] != y[31]))) begin
            r.res = 32'h7FC00000;
            r.nv  = 1'b1;
            return r;
        end
        if (xinf) begin r.res = x; return r; end
        if (yinf) begin r.res = y; return r; end
        s = val_of(x) + val_of(y);
        if (s == 0) begin r.res = {zs, 31'd0}; return r; end
        rs  = s < 0;
        mag = rs ? 300'(-s) : 300'(s);
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p < 23) begin
`ifdef FADD_PIPE_DENORM_EN
            r.res = {rs, 8'h00, mag[22:0]};
`else
            r.res = {zs, 31'd0};
`endif
            return r;
        end
        sh   = p - 23;
        keep = 25'(mag >> sh);
        rem  = mag & ((300'd1 << sh) - 300'd1);
        half = (sh == 0) ? 300'd0 : (300'd1 << (sh - 1));
        if (sh > 0 && (rem > half || (rem == half && keep[0]))) keep = keep + 25'd1;
        if (keep[24]) begin keep = keep >> 1; sh++; end
        if (sh + 1 >= 255) begin
            r.res = {rs, 8'hFF, 23'd0};
            r.ovf = 1'b1;
            return r;
        end
        r.res = {rs, 8'(sh + 1), keep[22:0]};
        return r;
    endfunction

    // Scoreboard: expectation pushed on each operand transfer, popped on each result transfer.
    rslt_t       sb_q[$];
    logic [31:0] got_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (in_valid && in_ready) sb_q.push_back(model(a, b));
            if (out_valid && out_ready) begin
                got_q.push_back(res);
                if (sb_q.size() == 0) begin
                    check("unexpected_result", {32'd0, res}, 64'hDEAD);
                end else begin
                    rslt_t e;
                    e = sb_q.pop_front();
                    check("res_vs_model", {32'd0, res}, {32'd0, e.res});
                    check("flags_vs_model", {62'd0, ovf, nv}, {62'd0, e.ovf, e.nv});
                end
            end
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y);
        int n;
        n = 0;
        in_valid = 1'b1;
        a = x;
        b = y;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("send_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

`ifdef FADD_PIPE_DENORM_EN
    localparam logic [31:0] D10 = 32'h00000002;
    localparam logic [31:0] D11 = 32'h007FFFFF;
    localparam logic [31:0] D17 = 32'h00000001;
`else
    localparam logic [31:0] D10 = 32'h00000000;
    localparam logic [31:0] D11 = 32'h00800000;
    localparam logic [31:0] D17 = 32'h00000000;
`endif

    vec_t tbl [20];
    logic [31:0] bp_exp [4];
    bit rnd_done;

    initial begin
        int n, base, cnt;
        tbl = '{
            '{32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0},
            '{32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0, 1'b0},
            '{32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 1'b0},
            '{32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0, 1'b0},
            '{32'h3F800000, 32'h33800001, 32'h3F800001, 1'b0, 1'b0},
            '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0},
            '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b1},
            '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1},
            '{32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0, 1'b0},
            '{32'h00000001, 32'h00000001, D10,          1'b0, 1'b0},
            '{32'h00800000, 32'h80000001, D11,          1'b0, 1'b0},
            '{32'h80000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0},
            '{32'h00000000, 32'h80000000, 32'h00000000, 1'b0, 1'b0},
            '{32'h3FC00000, 32'hBF400000, 32'h3F400000, 1'b0, 1'b0},
            '{32'h40400000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0},
            '{32'h3F800000, 32'h00000000, 32'h3F800000, 1'b0, 1'b0},
            '{32'h00800001, 32'h80800000, D17,          1'b0, 1'b0},
            '{32'h7F800000, 32'h7F800000, 32'h7F800000, 1'b0, 1'b0},
            '{32'h4B800000, 32'h3F800000, 32'h4B800000, 1'b0, 1'b0},
            '{32'h4B800001, 32'h3F800000, 32'h4B800002, 1'b0, 1'b0}
        };
        bp_exp = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};

        // reset state, before any clock edge is released
        #12;
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_res", {32'd0, res}, 64'd0);
        check("reset_flags", {62'd0, ovf, nv}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // pin the reference model against hand-computed results
        for (int i = 0; i < 20; i++) begin
            rslt_t e;
            e = model(tbl[i].a, tbl[i].b);
            check($sformatf("model_vec%0d", i), {30'd0, e.res, e.ovf, e.nv},
                  {30'd0, tbl[i].res, tbl[i].ovf, tbl[i].nv});
        end
        for (int i = 0; i < 4; i++) begin
            rslt_t e;
            e = model(32'h3F800000 + (i == 0 ? 32'd0 : 32'h00800000 + 32'(i - 1) * 32'h00400000),
                      32'h3F800000 + (i == 0 ? 32'd0 : 32'h00800000 + 32'(i - 1) * 32'h00400000));
            if (i != 3) check($sformatf("model_bp%0d", i), {32'd0, e.res}, {32'd0, bp_exp[i]});
        end

        // latency: single operation, out_ready high
        in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000;
        @(negedge clk);
        check("lat_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        check("latency_cycles", 64'(n), 64'd3);
        check("lat_res", {32'd0, res}, 64'h40000000);
        @(posedge clk); #1;
        drain();

        // directed vectors back-to-back, checked against literals and model
        base = got_q.size();
        for (int i = 0; i < 20; i++) send(tbl[i].a, tbl[i].b);
        in_valid = 1'b0;
        drain();
        for (int i = 0; i < 20; i++)
            if (base + i < got_q.size())
                check($sformatf("dut_vec%0d", i), {32'd0, got_q[base + i]}, {32'd0, tbl[i].res});
        check("dut_vec_count", 64'(got_q.size() - base), 64'd20);

        // backpressure: stall the sink for 5 cycles after the first result
        base = got_q.size();
        out_ready = 1'b0;
        fork
            begin
                send(32'h3F800000, 32'h3F800000);
                send(32'h40000000, 32'h40000000);
                send(32'h40400000, 32'h40400000);
                send(32'h40800000, 32'h40800000);
                in_valid = 1'b0;
            end
            begin
                int m;
                logic [31:0] held;
                m = 0;
                while (!out_valid && m < 50) begin @(negedge clk); m++; end
                check("bp_first_valid", {63'd0, out_valid}, 64'd1);
                held = res;
                for (int i = 0; i < 5; i++) begin
                    check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
                    check("bp_res_held", {32'd0, res}, {32'd0, held});
                    @(negedge clk);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 64'(got_q.size() - base), 64'd4);
        for (int i = 0; i < 4; i++)
            if (base + i < got_q.size())
                check($sformatf("bp_order%0d", i), {32'd0, got_q[base + i]}, {32'd0, bp_exp[i]});

        // asynchronous reset with two operations in flight
        out_ready = 1'b0;
        send(32'h3F800000, 32'h3F800000);
        send(32'h40000000, 32'h40000000);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        check("rst_pre_valid", {63'd0, out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", {63'd0, out_valid}, 64'd0);
        check("rst_async_res", {32'd0, res}, 64'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("rst_no_stale", 64'(cnt), 64'd0);
        @(posedge clk); #1;

        // mixed operands with a randomly stalling sink
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [31:0] x, y;
                    x = $urandom;
                    case ($urandom_range(0, 3))
                        0: y = $urandom;
                        1: y = {~x[31], x[30:0]} ^ 32'($urandom_range(0, 255));
                        2: y = {x[31] ^ 1'($urandom_range(0, 1)),
                                8'(x[30:23] - 8'($urandom_range(0, 30))), 23'($urandom)};
                        default: begin
                            x = {1'($urandom), 8'($urandom_range(0, 2)), 23'($urandom)};
                            y = {1'($urandom), 8'($urandom_range(0, 2)), 23'($urandom)};
                        end
                    endcase
                    send(x, y);
                end
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = 1'($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
